rdata_reorder_unit: RTL and testbench

RDATA_REORDER_UNIT -- requirements
Module: rdata_reorder_unit

---
 rtl/rdata_reorder_pkg.sv | 22 ++
 rtl/rdata_reorder_mem.sv | 48 ++++
 rtl/rdata_reorder_unit.sv | 210 +++++++++++++++++++++
 tb/tb_rdata_reorder_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rdata_reorder_pkg.sv
// Shared constants and types for the read-data reorder unit: parameter defaults,
// depacketiser flit-type codes and the control FSM state encoding.
package rdata_reorder_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_SN_W   = 5;
  localparam int DEF_TO_W   = 10;

  typedef enum logic [1:0] {
    FLIT_HDR        = 2'd0,
    FLIT_RDATA_BODY = 2'd1,
    FLIT_WRESP      = 2'd2,
    FLIT_TAIL       = 2'd3
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/rdata_reorder_mem.sv
// Reorder storage: 2^SN_W payload slots with a valid vector, one write port,
// one clear-on-read read port and a second valid lookup used for duplicate checks.
module rdata_reorder_mem
  import rdata_reorder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SN_W   = DEF_SN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_we,
  input  logic [SN_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [SN_W-1:0]   i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  input  logic [SN_W-1:0]   i_qaddr,
  output logic              o_qvalid
);

  localparam int DEPTH = 1 << SN_W;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  // Payload slots carry no reset; only the valid vector decides visibility.
  always_ff @(posedge clk) begin
    if (i_we) r_data[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      if (i_re) r_vld[i_raddr] <= 1'b0;
      if (i_we) r_vld[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata  = r_data[i_raddr];
  assign o_rvalid = r_vld[i_raddr];
  assign o_qvalid = r_vld[i_qaddr];

endmodule

// File: rtl/rdata_reorder_unit.sv
// Reorders out-of-order read-data beats of one burst into SN order for the slave-side FIFO.
// Optional watchdog/anomaly logic is built only when RDATA_REORDER_TIMEOUT_EN is defined.
module rdata_reorder_unit
  import rdata_reorder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SN_W   = DEF_SN_W,
  parameter int TO_W   = DEF_TO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SN_W-1:0]   burst_len,
  input  logic              in_valid,
  input  logic [SN_W-1:0]   in_sn,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err_dup,
  output logic              err_range,
  output logic              anomaly
);

  localparam int CNT_W = SN_W + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SN_W-1:0]   r_blen;
  logic [SN_W-1:0]   r_head;
  logic              r_wrap;
  logic [CNT_W-1:0]  r_rcv_cnt;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [CNT_W-1:0]  w_beats;
  logic              r_out_vld_p0;
  logic [DATA_W-1:0] r_out_data_p0;
  logic              r_err_dup;
  logic              r_err_range;

  logic              w_active;
  logic              w_start_acc;
  logic              w_acc;
  logic              w_range;
  logic              w_dup;
  logic              w_legal;
  logic              w_slot_free;
  logic              w_bypass;
  logic              w_load_mem;
  logic              w_load;
  logic              w_hs;
  logic              w_last_hs;
  logic              w_flush;
  logic              w_wdog_fire;
  logic              w_busy;
  logic              w_done;
  logic [DATA_W-1:0] w_mem_rdata;
  logic              w_head_vld;
  logic              w_q_vld;

  assign w_beats     = {1'b0, r_blen} + 1'b1;
  assign w_active    = (r_state == ST_ACTIVE);
  assign w_start_acc = start && (r_state == ST_IDLE);
  assign w_acc       = in_valid && w_active;

  // Once head has wrapped every SN of the burst has been emitted, so all later beats are stale.
  assign w_range = w_acc && (in_sn > r_blen);
  assign w_dup   = w_acc && !w_range && (w_q_vld || (in_sn < r_head) || r_wrap);
  assign w_legal = w_acc && !w_range && !w_dup;

  assign w_slot_free = !r_out_vld_p0 || out_ready;
  assign w_bypass    = w_legal && (in_sn == r_head) && w_slot_free;
  assign w_load_mem  = w_active && w_head_vld && w_slot_free;
  assign w_load      = w_bypass || w_load_mem;
  assign w_hs        = r_out_vld_p0 && out_ready;
  assign w_last_hs   = w_active && w_hs && ((r_out_cnt + 1'b1) == w_beats);
  assign w_flush     = w_start_acc || w_wdog_fire;

  rdata_reorder_mem #(
    .DATA_W (DATA_W),
    .SN_W   (SN_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (w_flush),
    .i_we     (w_legal && !w_bypass),
    .i_waddr  (in_sn),
    .i_wdata  (in_data),
    .i_re     (w_load_mem),
    .i_raddr  (r_head),
    .o_rdata  (w_mem_rdata),
    .o_rvalid (w_head_vld),
    .i_qaddr  (in_sn),
    .o_qvalid (w_q_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        w_busy = 1'b1;
        if (w_last_hs) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_wdog_fire) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blen       <= '0;
      r_head       <= '0;
      r_wrap       <= 1'b0;
      r_rcv_cnt    <= '0;
      r_out_cnt    <= '0;
      r_out_vld_p0 <= 1'b0;
      r_err_dup    <= 1'b0;
      r_err_range  <= 1'b0;
    end else if (w_start_acc) begin
      r_blen       <= burst_len;
      r_head       <= '0;
      r_wrap       <= 1'b0;
      r_rcv_cnt    <= '0;
      r_out_cnt    <= '0;
      r_out_vld_p0 <= 1'b0;
      r_err_dup    <= 1'b0;
      r_err_range  <= 1'b0;
    end else begin
      if (w_range) r_err_range <= 1'b1;
      if (w_dup)   r_err_dup   <= 1'b1;
      if (w_legal) r_rcv_cnt   <= r_rcv_cnt + 1'b1;
      if (w_hs)    r_out_cnt   <= r_out_cnt + 1'b1;
      if (w_load) begin
        r_out_vld_p0 <= 1'b1;
        r_head       <= r_head + 1'b1;
        if (r_head == {SN_W{1'b1}}) r_wrap <= 1'b1;
      end else if (out_ready) begin
        r_out_vld_p0 <= 1'b0;
      end
      if (w_wdog_fire) r_out_vld_p0 <= 1'b0;
    end
  end

  // Output stage: payload from bypass or head slot, held until the FIFO accepts it.
  always_ff @(posedge clk) begin
    if (w_load) r_out_data_p0 <= w_bypass ? in_data : w_mem_rdata;
  end

`ifdef RDATA_REORDER_TIMEOUT_EN
  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'((1 << TO_W) - 2);

  logic [TO_W-1:0] r_wdog;
  logic            r_anomaly;
  logic            w_wdog_cnt;

  // Fires on the cycle that would bring the count to its all-ones value.
  assign w_wdog_cnt  = w_active && !w_acc && (r_rcv_cnt < w_beats);
  assign w_wdog_fire = w_wdog_cnt && (r_wdog == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog    <= '0;
      r_anomaly <= 1'b0;
    end else if (w_start_acc) begin
      r_wdog    <= '0;
      r_anomaly <= 1'b0;
    end else if (w_acc) begin
      r_wdog <= '0;
    end else if (w_wdog_fire) begin
      r_wdog    <= '0;
      r_anomaly <= 1'b1;
    end else if (w_wdog_cnt) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign anomaly = r_anomaly;
`else
  logic w_unused_to;
  logic w_unused_rcv;

  assign w_wdog_fire  = 1'b0;
  assign anomaly      = 1'b0;
  assign w_unused_to  = (TO_W > 0);
  assign w_unused_rcv = ^r_rcv_cnt;
`endif

  assign out_valid = r_out_vld_p0;
  assign out_data  = r_out_data_p0;
  assign busy      = w_busy;
  assign done      = w_done;
  assign err_dup   = r_err_dup;
  assign err_range = r_err_range;

endmodule

// File: tb/tb_rdata_reorder_unit.sv
// Directed bench for rdata_reorder_unit; watchdog steps are built with RDATA_REORDER_TIMEOUT_EN.
module tb_rdata_reorder_unit;

  localparam int DATA_W = 64;
  localparam int SN_W   = 5;
`ifdef RDATA_REORDER_TIMEOUT_EN
  localparam int TO_W = 4;
`else
  localparam int TO_W = 10;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [SN_W-1:0]   burst_len;
  logic              in_valid;
  logic [SN_W-1:0]   in_sn;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err_dup;
  logic              err_range;
  logic              anomaly;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rdata_reorder_unit #(
    .DATA_W (DATA_W),
    .SN_W   (SN_W),
    .TO_W   (TO_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .in_valid  (in_valid),
    .in_sn     (in_sn),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err_dup   (err_dup),
    .err_range (err_range),
    .anomaly   (anomaly)
  );

  function automatic logic [63:0] fdat(input int b, input int sn);
    return {16'hA5A5, b[7:0], 32'h0, sn[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int sn, input int b);
    in_valid = v;
    in_sn    = sn[SN_W-1:0];
    in_data  = fdat(b, sn);
  endtask

  task automatic begin_burst(input int len);
    start     = 1'b1;
    burst_len = len[SN_W-1:0];
    tick();
    start = 1'b0;
  endtask

  int          got;
  int          hold_bad;
  logic [63:0] held;
  logic        pend;
  logic        seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = '0; in_valid = 1'b0; in_sn = '0; in_data = '0;
    out_ready = 1'b1;
    tick(); tick();
    check("reset_outputs", {out_valid, busy, done, err_dup, err_range, anomaly}, 6'b0);
    rst = 1'b0;
    tick();

    // In-order burst of 4 with bypass latency of one cycle.
    begin_burst(3);
    check("t1_busy", busy, 1);
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, s, 1);
      tick();
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, fdat(1, s));
    end
    drive(1'b0, 0, 0);
    tick();
    check("t1_done_busy_valid", {done, busy, out_valid}, 3'b100);
    tick();
    check("t1_back_idle", {done, busy}, 2'b00);

    // Out-of-order 3,1,0,2.
    begin_burst(3);
    drive(1'b1, 3, 2); tick(); check("t2_wait_sn3", out_valid, 0);
    drive(1'b1, 1, 2); tick(); check("t2_wait_sn1", out_valid, 0);
    drive(1'b1, 0, 2); tick(); check("t2_first", {out_valid, out_data}, {1'b1, fdat(2, 0)});
    drive(1'b1, 2, 2); tick(); check("t2_beat1", {out_valid, out_data}, {1'b1, fdat(2, 1)});
    drive(1'b0, 0, 0); tick(); check("t2_beat2", {out_valid, out_data}, {1'b1, fdat(2, 2)});
    tick();                    check("t2_beat3", {out_valid, out_data}, {1'b1, fdat(2, 3)});
    tick();
    check("t2_done_flags", {done, busy, err_dup, err_range}, 4'b1000);
    tick();

    // Duplicate SN.
    begin_burst(1);
    drive(1'b1, 0, 3); tick(); check("t3_beat0", {out_valid, out_data}, {1'b1, fdat(3, 0)});
    drive(1'b1, 0, 9); tick(); check("t3_dup", {out_valid, err_dup}, 2'b01);
    drive(1'b1, 1, 3); tick(); check("t3_beat1", {out_valid, out_data}, {1'b1, fdat(3, 1)});
    drive(1'b0, 0, 0); tick();
    check("t3_done_flags", {done, err_dup, err_range}, 3'b110);
    tick();

    // Out-of-range SN, plus a start pulse while active that must be ignored.
    begin_burst(2);
    check("t4_err_cleared", err_dup, 0);
    drive(1'b1, 5, 4); tick(); check("t4_range", {err_range, out_valid}, 2'b10);
    drive(1'b1, 0, 4); tick(); check("t4_beat0", {out_valid, out_data}, {1'b1, fdat(4, 0)});
    drive(1'b1, 1, 4); start = 1'b1; burst_len = '0; tick(); start = 1'b0;
    check("t4_beat1", {out_valid, out_data}, {1'b1, fdat(4, 1)});
    drive(1'b1, 2, 4); tick(); check("t4_beat2", {out_valid, out_data}, {1'b1, fdat(4, 2)});
    drive(1'b0, 0, 0); tick();
    check("t4_done_flags", {done, err_range, err_dup}, 3'b110);
    tick();

    // Backpressure hold, then asynchronous reset mid-burst.
    begin_burst(3);
    out_ready = 1'b0;
    drive(1'b1, 2, 5); tick();
    drive(1'b1, 3, 5); tick();
    drive(1'b1, 0, 5); tick(); check("t5_beat0", {out_valid, out_data}, {1'b1, fdat(5, 0)});
    drive(1'b1, 1, 5); tick(); check("t5_hold_a", {out_valid, out_data}, {1'b1, fdat(5, 0)});
    drive(1'b0, 0, 0); tick(); check("t5_hold_b", {out_valid, out_data}, {1'b1, fdat(5, 0)});
    #2 rst = 1'b1;
    #1;
    check("t5_abort", {out_valid, busy, done, err_dup, err_range, anomaly}, 6'b0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_done", {done, busy}, 2'b00);
    out_ready = 1'b1;
    begin_burst(3);
    drive(1'b1, 0, 6); tick(); check("t5_new0", {out_valid, out_data}, {1'b1, fdat(6, 0)});
    drive(1'b1, 1, 6); tick(); check("t5_new1", {out_valid, out_data}, {1'b1, fdat(6, 1)});
    drive(1'b0, 0, 0); tick(); check("t5_stale_a", out_valid, 0);
    tick();                    check("t5_stale_b", out_valid, 0);
    drive(1'b1, 2, 6); tick(); check("t5_new2", {out_valid, out_data}, {1'b1, fdat(6, 2)});
    drive(1'b1, 3, 6); tick(); check("t5_new3", {out_valid, out_data}, {1'b1, fdat(6, 3)});
    drive(1'b0, 0, 0); tick(); check("t5_done", done, 1);
    tick();

    // Full-depth reversed burst with out_ready toggling every cycle.
    begin_burst(31);
    got = 0; hold_bad = 0; held = '0; pend = 1'b0; seen_done = 1'b0;
    for (int i = 0; i < 400 && !seen_done; i++) begin
      if (i < 32) drive(1'b1, 31 - i, 7);
      else        drive(1'b0, 0, 0);
      out_ready = i[0];
      if (out_valid && out_ready) begin
        check("t6_beat", out_data, fdat(7, got));
        got++;
      end
      pend = out_valid && !out_ready;
      held = out_data;
      tick();
      if (pend && (!out_valid || out_data !== held)) hold_bad++;
      if (done) seen_done = 1'b1;
    end
    check("t6_count", got, 32);
    check("t6_hold", hold_bad, 0);
    check("t6_done", seen_done, 1);
    check("t6_flags", {err_dup, err_range}, 2'b00);
    out_ready = 1'b1;
    tick();

    // Beats while idle are dropped silently.
    drive(1'b1, 5, 8); tick(); tick();
    drive(1'b0, 0, 0);
    check("t7_idle_drop", {err_dup, err_range, busy, out_valid}, 4'b0);

`ifdef RDATA_REORDER_TIMEOUT_EN
    // Watchdog: one beat of four, then silence.
    begin_burst(3);
    drive(1'b1, 0, 9); tick(); check("t8_beat0", {out_valid, out_data}, {1'b1, fdat(9, 0)});
    drive(1'b0, 0, 0);
    repeat (14) tick();
    check("t8_before", {anomaly, busy}, 2'b01);
    tick();
    check("t8_fire", {anomaly, busy, done, out_valid}, 4'b1000);
    tick();
    check("t8_sticky", {anomaly, done}, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("t8_rst", {out_valid, busy, done, err_dup, err_range, anomaly}, 6'b0);
    tick();
    rst = 1'b0;
    tick();
    begin_burst(0);
    drive(1'b1, 0, 10); tick(); check("t8_after", {out_valid, out_data}, {1'b1, fdat(10, 0)});
    drive(1'b0, 0, 0); tick(); check("t8_done", {done, anomaly}, 2'b10);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
